// File: rtl/wavegen_pkg.sv
// Shared definitions for the waveform generator family: waveform mode
// encoding and a small helper to turn the raw mode input into the enum.
package wavegen_pkg;

    // Waveform selection as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_SAW = 2'd0,
        MODE_TRI = 2'd1,
        MODE_SQR = 2'd2,
        MODE_MID = 2'd3
    } mode_e;

    // Width of the duty-cycle control (units of 1/256 period).
    localparam int DUTY_W = 8;

    // Every 2-bit code is a legal mode, so the cast cannot produce an
    // out-of-range enum value.
    function automatic mode_e to_mode(input logic [1:0] raw);
        return mode_e'(raw);
    endfunction

endpackage : wavegen_pkg

// File: rtl/pdm_mod.sv
// First-order error-feedback PDM modulator. The ones density of pdm_out
// tracks pcm / 2^WIDTH; the residue of each accumulation is carried into
// the next cycle so no quantisation error is lost.
module pdm_mod #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pcm,
    output logic             pdm_out
);

    logic [WIDTH-1:0] r_err;
    logic             r_pdm;
    logic [WIDTH:0]   w_sum;

    // The carry out of error + sample is the output bit; the low bits are
    // the residue fed back next cycle.
    assign w_sum = {1'b0, r_err} + {1'b0, pcm};

    // Error accumulator and output bit, running every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
            r_pdm <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge value of its inputs; blocking
            // assignments here would make the result depend on statement order.
            r_err <= w_sum[WIDTH-1:0];
            r_pdm <= w_sum[WIDTH];
        end
    end

    assign pdm_out = r_pdm;

endmodule : pdm_mod

// File: rtl/wavegen_pdm.sv
// Multi-mode audio waveform generator. A phase accumulator sets pitch; the
// top WIDTH bits of phase are shaped into saw, triangle, square or a
// midscale level, registered as pcm, and converted to a 1-bit PDM stream.
// Pitch, mode and duty are latched only when the accumulator wraps (or
// while the step is zero), so a period is never altered part-way through.
module wavegen_pdm
    import wavegen_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ACC_W  = 24,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [DUTY_W-1:0] duty,
    output logic [WIDTH-1:0]  pcm,
    output logic              pdm_out,
    output logic              wrap
);

    // Phase accumulator and the active (latched) configuration.
    logic [ACC_W-1:0]  r_phase;
    logic [STEP_W-1:0] r_step_a;
    mode_e             r_mode_a;
    logic [DUTY_W-1:0] r_duty_a;

    // Registered outputs.
    logic [WIDTH-1:0]  r_pcm;
    logic              r_wrap;

    // Next-phase arithmetic and waveform shaping.
    logic [ACC_W:0]    w_sum;
    logic              w_carry;
    logic              w_load;
    logic [WIDTH-1:0]  w_p;
    logic [WIDTH-1:0]  w_s;
    logic [WIDTH-1:0]  w_sample;
    logic              w_pdm;

    // One extra bit on the add captures the carry that defines a wrap. The
    // step is zero-extended to the accumulator width.
    assign w_sum   = {1'b0, r_phase} + {{(ACC_W - STEP_W + 1){1'b0}}, r_step_a};
    assign w_carry = w_sum[ACC_W];

    // New configuration is accepted at a period boundary, or continuously
    // while idle with a zero step (which would otherwise never wrap).
    assign w_load  = ena && (w_carry || (r_step_a == '0));

    // Waveform index: the top WIDTH bits of phase, and its doubled form used
    // to build the two triangle ramps.
    assign w_p     = r_phase[ACC_W-1 -: WIDTH];
    assign w_s     = {w_p[WIDTH-2:0], 1'b0};

    // Waveform mux from the current (pre-update) phase and active mode.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no
        // latch is inferred even if the case is later edited.
        w_sample = {1'b1, {(WIDTH-1){1'b0}}};
        unique case (r_mode_a)
            MODE_SAW: w_sample = w_p;
            MODE_TRI: w_sample = w_p[WIDTH-1] ? ~w_s : w_s;
            MODE_SQR: w_sample = (w_p[WIDTH-1 -: DUTY_W] < r_duty_a) ? '1 : '0;
            MODE_MID: w_sample = {1'b1, {(WIDTH-1){1'b0}}};
        endcase
    end

    // Accumulator, config latch, pcm register and wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= '0;
            r_step_a <= '0;
            r_mode_a <= MODE_SAW;
            r_duty_a <= '0;
            r_pcm    <= '0;
            r_wrap   <= 1'b0;
        end else if (ena) begin
            // The add uses the step that was active before any load below.
            r_phase <= w_sum[ACC_W-1:0];
            r_wrap  <= w_carry;
            r_pcm   <= w_sample;
            if (w_load) begin
                r_step_a <= step;
                r_mode_a <= to_mode(mode);
                r_duty_a <= duty;
            end
        end else begin
            // Held: phase, config and pcm keep their values; wrap never
            // lingers beyond one cycle.
            r_wrap <= 1'b0;
        end
    end

    // PCM to 1-bit conversion of the registered sample.
    pdm_mod #(
        .WIDTH (WIDTH)
    ) u_pdm_mod (
        .clk     (clk),
        .rst_n   (rst_n),
        .pcm     (r_pcm),
        .pdm_out (w_pdm)
    );

    assign pcm     = r_pcm;
    assign wrap    = r_wrap;
    assign pdm_out = w_pdm;

endmodule : wavegen_pdm

// File: tb/tb_wavegen_pdm.sv
// Scoreboard bench for wavegen_pdm at WIDTH=8, ACC_W=12, STEP_W=8.
// The stimulus process drives one cycle of inputs, advances an integer
// reference model and queues the expected outputs; the monitor compares
// the DUT against the queue one cycle later.
module tb_wavegen_pdm;

    localparam int WIDTH  = 8;
    localparam int ACC_W  = 12;
    localparam int STEP_W = 8;
    localparam int ACC_MOD = 1 << ACC_W;
    localparam int PCM_MOD = 1 << WIDTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step;
    logic [7:0]        duty;
    logic [WIDTH-1:0]  pcm;
    logic              pdm_out;
    logic              wrap;

    wavegen_pdm #(
        .WIDTH  (WIDTH),
        .ACC_W  (ACC_W),
        .STEP_W (STEP_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .mode    (mode),
        .step    (step),
        .duty    (duty),
        .pcm     (pcm),
        .pdm_out (pdm_out),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pcm;
        int pdm;
        int wrap;
    } exp_t;

    exp_t q[$];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state (plain integers).
    int m_phase, m_step, m_mode, m_duty, m_pcm, m_err, m_wrap;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Ideal waveform value for a phase, from the mode definitions.
    function automatic int wave(input int md, input int ph, input int dt);
        int p;
        p = ph / (ACC_MOD / PCM_MOD);
        case (md)
            0:       return p;
            1:       return (p < PCM_MOD / 2) ? 2 * p : (2 * PCM_MOD - 1) - 2 * p;
            2:       return (p < dt) ? PCM_MOD - 1 : 0;
            default: return PCM_MOD / 2;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_step = 0; m_mode = 0; m_duty = 0;
        m_pcm = 0; m_err = 0; m_wrap = 0;
    endtask

    // Apply inputs for the coming edge and queue the expected result.
    task automatic apply(input bit e, input int md, input int st, input int dt);
        int   total, sum;
        bit   carry;
        exp_t x;
        ena  = e;
        mode = md[1:0];
        step = st[STEP_W-1:0];
        duty = dt[7:0];
        // Modulator: carry of err + current pcm is the next bit.
        sum   = m_err + m_pcm;
        x.pdm = (sum >= PCM_MOD) ? 1 : 0;
        m_err = sum % PCM_MOD;
        if (e) begin
            total = m_phase + m_step;
            carry = (total >= ACC_MOD);
            m_pcm = wave(m_mode, m_phase, m_duty);
            if (carry || m_step == 0) begin
                m_step = st; m_mode = md; m_duty = dt;
            end
            m_phase = total % ACC_MOD;
            m_wrap  = carry ? 1 : 0;
        end else begin
            m_wrap = 0;
        end
        x.pcm  = m_pcm;
        x.wrap = m_wrap;
        q.push_back(x);
    endtask

    task automatic drive(input bit e, input int md, input int st, input int dt);
        @(negedge clk);
        apply(e, md, st, dt);
    endtask

    // Monitor: compare DUT outputs against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                check("pcm", int'(pcm), e.pcm);
                check("pdm_out", int'(pdm_out), e.pdm);
                check("wrap", int'(wrap), e.wrap);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int ones;
        bit found;
        rst_n = 1'b0;
        ena = 1'b0; mode = 2'd0; step = '0; duty = '0;
        model_reset();
        #1;
        check("reset_pcm", int'(pcm), 0);
        check("reset_pdm", int'(pdm_out), 0);
        check("reset_wrap", int'(wrap), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply(1, 0, 16, 0);

        // Saw, step 16: one pcm code per cycle, one wrap per 256 cycles.
        repeat (600) drive(1, 0, 16, 0);
        // Triangle, loaded at the next wrap.
        repeat (600) drive(1, 1, 16, 0);
        // Square at duty 64, then duty 0.
        repeat (600) drive(1, 2, 16, 64);
        repeat (400) drive(1, 2, 16, 0);
        // Midscale: pdm alternates.
        repeat (300) drive(1, 3, 16, 0);

        // Run saw until pcm sits at 0x40, then hold and count pdm ones.
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            drive(1, 0, 16, 0);
            if (m_mode == 0 && m_step == 16 && m_pcm == 64) found = 1'b1;
        end
        check("reach_pcm_0x40", int'(found), 1);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            drive(0, 0, 16, 0);
            @(posedge clk);
            #2;
            ones += int'(pdm_out);
        end
        check("pdm_ones_per_256_at_0x40", ones, 64);

        // Deferred config: switch to triangle with double step mid-period,
        // with an ena=0 burst before the wrap.
        repeat (40) drive(1, 0, 16, 0);
        repeat (60) drive(1, 1, 32, 0);
        repeat (12) drive(0, 1, 32, 0);
        repeat (400) drive(1, 1, 32, 0);

        // Asynchronous reset mid-period.
        repeat (77) drive(1, 0, 16, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_pcm", int'(pcm), 0);
        check("async_reset_pdm", int'(pdm_out), 0);
        check("async_reset_wrap", int'(wrap), 0);
        q.delete();
        model_reset();
        repeat (3) @(negedge clk);
        check("held_reset_pcm", int'(pcm), 0);
        rst_n = 1'b1;
        apply(1, 0, 16, 0);
        repeat (300) drive(1, 0, 16, 0);

        // Randomised segments of mode, step, duty and ena.
        for (int seg = 0; seg < 30; seg++) begin
            int md, st, dt, len;
            md  = int'($urandom_range(0, 3));
            st  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            dt  = int'($urandom_range(0, 255));
            len = int'($urandom_range(20, 300));
            for (int c = 0; c < len; c++)
                drive($urandom_range(0, 9) != 0, md, st, dt);
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wavegen_pdm

// File: doc/wavegen_pdm.md
# wavegen_pdm

- Parametrised multi-mode audio waveform generator with a built-in first-order PDM modulator.
- A phase accumulator with a programmable step sets pitch; a mode select picks sawtooth, triangle, variable-duty square, or midscale silence.
- Pitch, mode and duty changes are deferred to a phase wrap so waveforms never glitch mid-period.
- Sits between the switch/IO inputs and the top-level pins, which carry the PCM MSBs and the 1-bit PDM stream.

## Interface
Parameters:
- WIDTH, 16: PCM sample width (≥8).
- ACC_W, 24: phase accumulator width (≥WIDTH).
- STEP_W, 16: phase step input width (≤ACC_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ena  in  1  advance enable; when low, phase and PCM hold.
- mode  in  2  0 saw, 1 triangle, 2 square, 3 midscale.
- step  in  STEP_W  phase increment per enabled cycle, zero-extended to ACC_W.
- duty  in  8  square high fraction, in units of 1/256 period.
- pcm  out  WIDTH  registered unsigned sample.
- pdm_out  out  1  registered PDM bit.
- wrap  out  1  one-cycle pulse on accumulator carry-out.

## Operation
- Reset values: phase=0, step_a=0, mode_a=0, duty_a=0, pcm=0, pdm_out=0, wrap=0, modulator error=0.
- Active config (step_a, mode_a, duty_a) loads from the inputs on an enabled cycle when either:
  - the accumulator carries (same edge as the wrap pulse), or
  - step_a==0 (idle: a zero step would never wrap).
- Enabled cycle: {carry, phase} <= phase + step_a, modulo 2^ACC_W; wrap <= carry.
- The add uses the pre-load step_a value.
- ena low: phase, config and pcm hold; wrap <= 0.
- Define p = phase[ACC_W-1 -: WIDTH] and s = {p[WIDTH-2:0],1'b0}.
- pcm <= f(mode_a, p) on enabled cycles, computed from the current (pre-update) phase:
  - saw: p.
  - triangle: s if p[WIDTH-1]==0, else ~s.
  - square: all-ones if p[WIDTH-1 -: 8] < duty_a, else 0.
    - duty_a=0 gives constant 0; duty_a=255 gives high for 255/256 of the period.
  - midscale: 2^(WIDTH-1).
- PDM modulator runs every cycle regardless of ena:
  - sum[WIDTH:0] = err + pcm; pdm_out <= sum[WIDTH]; err <= sum[WIDTH-1:0].
  - Ones density equals pcm/2^WIDTH.
- Simultaneous wrap and input change: new values take effect on the wrap edge; the next period uses them.
- Reset mid-operation clears all state immediately (async). After release, the first enabled cycle loads config and adds 0.

## Timing
- pcm lags phase by one cycle.
- pdm_out reflects pcm one cycle later (pcm→pdm latency 1).
- wrap asserts in the cycle after the carrying add and lasts exactly one cycle.
- Config change to audible effect: at most one full period plus 1 cycle.
- No combinational paths from inputs to outputs.

## Structure
- Shared package wavegen_pkg:
  - MODE_SAW=2'd0, MODE_TRI=2'd1, MODE_SQR=2'd2, MODE_MID=2'd3.
  - The mode typedef.
- Sub-module pdm_mod (parameter WIDTH): clk, rst_n, pcm in, pdm_out out.
  - First-order error-feedback modulator, reused wherever a PCM→1-bit path is needed.
- Top of wavegen_pdm: accumulator, config latch, waveform mux, pcm register.

## Test plan
All scenarios use WIDTH=8, ACC_W=12, STEP_W=8.
- Saw: ena=1, mode=0, step=16.
  - After config load, pcm counts 0,1,…,255,0.
  - wrap pulses exactly once per 256 enabled cycles.
- Triangle: mode=1, step=16.
  - pcm runs 0,2,…,254 then 255,253,…,1, repeating.
  - Peak-to-trough time is 128 cycles.
- Square: mode=2, step=16, duty=64.
  - pcm=255 for 64 cycles then 0 for 192 cycles.
  - duty=0 gives all zeros.
- PDM density:
  - mode=3 (pcm=0x80): pdm_out alternates 0,1,0,1.
  - Saw held at pcm=0x40 (ena=0): exactly 64 ones per 256 cycles.
- Deferred config:
  - Mid-period, change mode 0→1 and step 16→32.
  - pcm continues saw until the next wrap, then becomes a triangle with double slope.
  - A burst of ena=0 mid-period holds pcm constant and resumes without a step.
- Reset: drop rst_n mid-period.
  - pcm, pdm_out, wrap go 0 asynchronously.
  - After release, the sequence restarts from pcm=0.
